// File: rtl/display_value_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | display_value_sequencer                                                    |
// | Every FRAME_DIV VGA frames: capture clamped temperature/humidity, convert  |
// | to BCD (double-dabble, 1 bit/cycle), commit. Optional FREEZE input is      |
// | enabled by macro DISP_SEQ_FREEZE_EN.                                       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module display_value_sequencer #(
  parameter int FRAME_DIV = 30,
  parameter int TEMP_MAX  = 999,
  parameter int HUM_MAX   = 99
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        VGA_VS,
`ifdef DISP_SEQ_FREEZE_EN
  input  logic        FREEZE,
`endif
  input  logic [9:0]  TEMP_RAW,
  input  logic [6:0]  HUM_RAW,
  output logic [11:0] TEMP_BCD,
  output logic [7:0]  HUM_BCD,
  output logic        TEMP_OVR,
  output logic        HUM_OVR,
  output logic        UPDATE_PULSE,
  output logic        BUSY
);

  localparam logic [7:0] DIV_LAST     = 8'(FRAME_DIV - 1);
  localparam logic [9:0] TEMP_CEIL    = 10'(TEMP_MAX);
  localparam logic [6:0] HUM_CEIL     = 7'(HUM_MAX);
  localparam logic [3:0] T_STEP_LAST  = 4'd9;
  localparam logic [3:0] H_STEP_LAST  = 4'd6;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_CONV_T  = 3'd2,
    S_CONV_H  = 3'd3,
    S_COMMIT  = 3'd4
  } state_t;

  function automatic logic [3:0] dabble(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  logic        freeze;
`ifdef DISP_SEQ_FREEZE_EN
  assign freeze = FREEZE;
`else
  assign freeze = 1'b0;
`endif

  logic        vs_q;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  state_t      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [9:0]  t_bin_q, t_bin_d;
  logic [11:0] t_bcd_q, t_bcd_d;
  logic [6:0]  h_bin_q, h_bin_d;
  logic [7:0]  h_bcd_q, h_bcd_d;
  logic        t_ovr_q, t_ovr_d;
  logic        h_ovr_q, h_ovr_d;
  logic [11:0] temp_bcd_q, temp_bcd_d;
  logic [7:0]  hum_bcd_q, hum_bcd_d;
  logic        temp_ovr_q, temp_ovr_d;
  logic        hum_ovr_q, hum_ovr_d;
  logic        pulse_q, pulse_d;

  logic        trigger;
  logic        update_req;
  logic [11:0] t_adj;
  logic [7:0]  h_adj;

  // Falling edge of the active-low vertical sync starts a frame.
  assign trigger    = vs_q & ~VGA_VS;
  assign update_req = trigger & (frame_cnt_q == DIV_LAST);

  assign t_adj = {dabble(t_bcd_q[11:8]), dabble(t_bcd_q[7:4]), dabble(t_bcd_q[3:0])};
  assign h_adj = {dabble(h_bcd_q[7:4]), dabble(h_bcd_q[3:0])};

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (trigger) begin
      frame_cnt_d = (frame_cnt_q == DIV_LAST) ? 8'd0 : frame_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: begin
        // Requests outside IDLE are dropped; freeze only blocks new starts.
        if (update_req && !freeze) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        state_d = S_CONV_T;
        step_d  = 4'd0;
      end
      S_CONV_T: begin
        if (step_q == T_STEP_LAST) begin
          state_d = S_CONV_H;
          step_d  = 4'd0;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      S_CONV_H: begin
        if (step_q == H_STEP_LAST) begin
          state_d = S_COMMIT;
          step_d  = 4'd0;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        step_d  = 4'd0;
      end
    endcase
  end

  always_comb begin
    t_bin_d    = t_bin_q;
    t_bcd_d    = t_bcd_q;
    h_bin_d    = h_bin_q;
    h_bcd_d    = h_bcd_q;
    t_ovr_d    = t_ovr_q;
    h_ovr_d    = h_ovr_q;
    temp_bcd_d = temp_bcd_q;
    hum_bcd_d  = hum_bcd_q;
    temp_ovr_d = temp_ovr_q;
    hum_ovr_d  = hum_ovr_q;
    pulse_d    = 1'b0;
    case (state_q)
      S_CAPTURE: begin
        t_ovr_d = (TEMP_RAW > TEMP_CEIL);
        h_ovr_d = (HUM_RAW > HUM_CEIL);
        t_bin_d = (TEMP_RAW > TEMP_CEIL) ? TEMP_CEIL : TEMP_RAW;
        h_bin_d = (HUM_RAW > HUM_CEIL) ? HUM_CEIL : HUM_RAW;
        t_bcd_d = '0;
        h_bcd_d = '0;
      end
      S_CONV_T: begin
        {t_bcd_d, t_bin_d} = {t_adj, t_bin_q} << 1;
      end
      S_CONV_H: begin
        {h_bcd_d, h_bin_d} = {h_adj, h_bin_q} << 1;
      end
      S_COMMIT: begin
        temp_bcd_d = t_bcd_q;
        hum_bcd_d  = h_bcd_q;
        temp_ovr_d = t_ovr_q;
        hum_ovr_d  = h_ovr_q;
        pulse_d    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      vs_q        <= 1'b1;
      frame_cnt_q <= '0;
      state_q     <= S_IDLE;
      step_q      <= '0;
      t_bin_q     <= '0;
      t_bcd_q     <= '0;
      h_bin_q     <= '0;
      h_bcd_q     <= '0;
      t_ovr_q     <= 1'b0;
      h_ovr_q     <= 1'b0;
      temp_bcd_q  <= '0;
      hum_bcd_q   <= '0;
      temp_ovr_q  <= 1'b0;
      hum_ovr_q   <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      vs_q        <= VGA_VS;
      frame_cnt_q <= frame_cnt_d;
      state_q     <= state_d;
      step_q      <= step_d;
      t_bin_q     <= t_bin_d;
      t_bcd_q     <= t_bcd_d;
      h_bin_q     <= h_bin_d;
      h_bcd_q     <= h_bcd_d;
      t_ovr_q     <= t_ovr_d;
      h_ovr_q     <= h_ovr_d;
      temp_bcd_q  <= temp_bcd_d;
      hum_bcd_q   <= hum_bcd_d;
      temp_ovr_q  <= temp_ovr_d;
      hum_ovr_q   <= hum_ovr_d;
      pulse_q     <= pulse_d;
    end
  end

  assign TEMP_BCD     = temp_bcd_q;
  assign HUM_BCD      = hum_bcd_q;
  assign TEMP_OVR     = temp_ovr_q;
  assign HUM_OVR      = hum_ovr_q;
  assign UPDATE_PULSE = pulse_q;
  assign BUSY         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_display_value_sequencer.sv
`default_nettype none
// Two sequencers (FRAME_DIV 1 and 3) on shared stimulus, compared every cycle
// against a frame-count / commit-schedule model with decimal digit arithmetic.
module tb_display_value_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        vga_vs = 1'b1;
  logic [9:0]  temp_raw = '0;
  logic [6:0]  hum_raw = '0;
`ifdef DISP_SEQ_FREEZE_EN
  logic        freeze = 1'b0;
`endif

  logic [11:0] tbcd1, tbcd3;
  logic [7:0]  hbcd1, hbcd3;
  logic        tovr1, tovr3, hovr1, hovr3, upd1, upd3, busy1, busy3;

  always #5 clk = ~clk;

  display_value_sequencer #(.FRAME_DIV(1), .TEMP_MAX(999), .HUM_MAX(99)) u_dut1 (
    .CLOCK_50(clk), .RESET_N(rst_n), .VGA_VS(vga_vs),
`ifdef DISP_SEQ_FREEZE_EN
    .FREEZE(freeze),
`endif
    .TEMP_RAW(temp_raw), .HUM_RAW(hum_raw),
    .TEMP_BCD(tbcd1), .HUM_BCD(hbcd1), .TEMP_OVR(tovr1), .HUM_OVR(hovr1),
    .UPDATE_PULSE(upd1), .BUSY(busy1)
  );

  display_value_sequencer #(.FRAME_DIV(3), .TEMP_MAX(999), .HUM_MAX(99)) u_dut3 (
    .CLOCK_50(clk), .RESET_N(rst_n), .VGA_VS(vga_vs),
`ifdef DISP_SEQ_FREEZE_EN
    .FREEZE(freeze),
`endif
    .TEMP_RAW(temp_raw), .HUM_RAW(hum_raw),
    .TEMP_BCD(tbcd3), .HUM_BCD(hbcd3), .TEMP_OVR(tovr3), .HUM_OVR(hovr3),
    .UPDATE_PULSE(upd3), .BUSY(busy3)
  );

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          pulses1 = 0;
  int          pulses3 = 0;
  bit          rnd = 1'b0;
  int          temp_cur = 0;
  int          hum_cur = 0;

  // Reference model: frame counters, start cycle of an accepted update, captured values.
  bit          m_vs_prev = 1'b1;
  int          m_div  [2] = '{1, 3};
  int          m_fcnt [2];
  bit          m_act  [2];
  int          m_t0   [2];
  int          cap_t  [2];
  int          cap_h  [2];
  bit          cap_to [2];
  bit          cap_ho [2];
  logic [11:0] e_tbcd [2];
  logic [7:0]  e_hbcd [2];
  bit          e_tovr [2];
  bit          e_hovr [2];

  function automatic bit frz();
`ifdef DISP_SEQ_FREEZE_EN
    return freeze;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_busy(int k, int c);
    return m_act[k] && (c >= m_t0[k] + 1) && (c <= m_t0[k] + 19);
  endfunction

  task automatic model_reset();
    m_vs_prev = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_fcnt[k] = 0;
      m_act[k]  = 1'b0;
      e_tbcd[k] = '0;
      e_hbcd[k] = '0;
      e_tovr[k] = 1'b0;
      e_hovr[k] = 1'b0;
    end
  endtask

  task automatic model_eval();
    bit trig;
    bit wrap;
    trig = m_vs_prev && !vga_vs;
    for (int k = 0; k < 2; k++) begin
      if (m_act[k] && cyc == m_t0[k] + 1) begin
        cap_to[k] = (temp_raw > 10'd999);
        cap_ho[k] = (hum_raw > 7'd99);
        cap_t[k]  = cap_to[k] ? 999 : int'(temp_raw);
        cap_h[k]  = cap_ho[k] ? 99 : int'(hum_raw);
      end
      if (trig) begin
        wrap = (m_fcnt[k] == m_div[k] - 1);
        m_fcnt[k] = wrap ? 0 : m_fcnt[k] + 1;
        if (wrap && !m_busy(k, cyc) && !frz()) begin
          m_act[k] = 1'b1;
          m_t0[k]  = cyc;
        end
      end
    end
    m_vs_prev = vga_vs;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_dut(int k, logic [11:0] tb, logic [7:0] hb, logic to, logic ho,
                         logic up, logic bz, bit up_e);
    string n;
    n = (k == 0) ? "div1" : "div3";
    chk({n, ".TEMP_BCD"},     32'(tb), 32'(e_tbcd[k]));
    chk({n, ".HUM_BCD"},      32'(hb), 32'(e_hbcd[k]));
    chk({n, ".TEMP_OVR"},     32'(to), 32'(e_tovr[k]));
    chk({n, ".HUM_OVR"},      32'(ho), 32'(e_hovr[k]));
    chk({n, ".UPDATE_PULSE"}, 32'(up), 32'(up_e));
    chk({n, ".BUSY"},         32'(bz), 32'(m_busy(k, cyc)));
  endtask

  task automatic check_all();
    bit up_e [2];
    for (int k = 0; k < 2; k++) begin
      up_e[k] = 1'b0;
      if (m_act[k] && cyc == m_t0[k] + 20) begin
        e_tbcd[k] = {4'(cap_t[k] / 100), 4'((cap_t[k] / 10) % 10), 4'(cap_t[k] % 10)};
        e_hbcd[k] = {4'(cap_h[k] / 10), 4'(cap_h[k] % 10)};
        e_tovr[k] = cap_to[k];
        e_hovr[k] = cap_ho[k];
        m_act[k]  = 1'b0;
        up_e[k]   = 1'b1;
      end
    end
    if (upd1 === 1'b1) pulses1++;
    if (upd3 === 1'b1) pulses3++;
    chk_dut(0, tbcd1, hbcd1, tovr1, hovr1, upd1, busy1, up_e[0]);
    chk_dut(1, tbcd3, hbcd3, tovr3, hovr3, upd3, busy3, up_e[1]);
  endtask

  task automatic cyc_step(logic vs, logic [9:0] t, logic [6:0] h);
    vga_vs   = vs;
    temp_raw = t;
    hum_raw  = h;
    model_eval();
    @(posedge clk);
    cyc++;
    #1;
    check_all();
  endtask

  task automatic run(logic vs, int n);
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        temp_cur = int'($urandom_range(0, 1023));
        hum_cur  = int'($urandom_range(0, 127));
      end
      cyc_step(vs, 10'(temp_cur), 7'(hum_cur));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) begin
      @(posedge clk);
      cyc++;
      #1;
      check_all();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();
    run(1'b1, 5);

    // Nominal conversion
    temp_cur = 725; hum_cur = 45;
    run(1'b0, 2); run(1'b1, 28);
    chk("r028.temp", 32'(tbcd1), 32'h725);
    chk("r028.hum",  32'(hbcd1), 32'h45);
    chk("r028.ovr",  32'({tovr1, hovr1}), 32'h0);

    // Over-range clamp
    temp_cur = 1023; hum_cur = 120;
    run(1'b0, 1); run(1'b1, 30);
    chk("r029.temp", 32'(tbcd1), 32'h999);
    chk("r029.hum",  32'(hbcd1), 32'h99);
    chk("r029.ovr",  32'({tovr1, hovr1}), 32'h3);

    // Frame division by 3
    do_reset();
    pulses3 = 0;
    temp_cur = 123; hum_cur = 7;
    repeat (6) begin
      run(1'b0, 1); run(1'b1, 99);
    end
    chk("r030.pulses3", 32'(pulses3), 32'd2);

    // Request during conversion dropped; late input change ignored
    pulses1 = 0;
    temp_cur = 300; hum_cur = 50;
    run(1'b0, 1); run(1'b1, 2);
    temp_cur = 400;
    run(1'b1, 2); run(1'b0, 1); run(1'b1, 30);
    chk("r031.temp",    32'(tbcd1), 32'h300);
    chk("r031.pulses1", 32'(pulses1), 32'd1);

    // Reset mid-conversion aborts
    pulses1 = 0;
    temp_cur = 555; hum_cur = 66;
    run(1'b0, 1); run(1'b1, 7);
    do_reset();
    run(1'b1, 40);
    chk("r032.pulses1", 32'(pulses1), 32'd0);
    chk("r032.temp",    32'(tbcd1), 32'h000);

    // Randomised frames and inputs
    rnd = 1'b1;
    repeat (40) begin
      run(1'b0, int'($urandom_range(1, 3)));
      run(1'b1, int'($urandom_range(4, 40)));
    end
    rnd = 1'b0;

`ifdef DISP_SEQ_FREEZE_EN
    do_reset();
    temp_cur = 321; hum_cur = 12;
    run(1'b0, 1); run(1'b1, 30);
    pulses1 = 0;
    freeze = 1'b1;
    temp_cur = 888;
    repeat (3) begin
      run(1'b0, 1); run(1'b1, 30);
    end
    freeze = 1'b0;
    chk("r033.frozen_pulses", 32'(pulses1), 32'd0);
    chk("r033.frozen_temp",   32'(tbcd1), 32'h321);
    run(1'b0, 1); run(1'b1, 30);
    chk("r033.resume_temp",   32'(tbcd1), 32'h888);
    temp_cur = 246;
    run(1'b0, 1); run(1'b1, 3);
    freeze = 1'b1;
    run(1'b1, 30);
    freeze = 1'b0;
    chk("r033.complete_temp", 32'(tbcd1), 32'h246);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
